uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver in the Pong serial path.
- Configurable data width, parity mode and stop-bit count.
- Synchronises the asynchronous RX line and takes a 3-sample majority vote per bit.
- Reports parity and framing errors alongside each received word.
- Sits between the board RX pin and the paddle/command decoder.

Parameters:
CLKS_PER_BIT, 217, system clocks per serial bit; legal range is 8 or more.
DATA_BITS, 8, data bits per frame; legal range is 5 to 9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits checked per frame; legal values are 1 or 2.

Ports:
i_Clock  input  1  system clock; single clock domain.
i_Reset  input  1  asynchronous, active-high reset.
i_RX_Input  input  1  raw serial line, asynchronous, idles high.
o_RX_Valid  output  1  one-cycle pulse when a frame completes.
o_RX_Byte  output  DATA_BITS  received word, LSB first on the wire.
o_Parity_Err  output  1  parity mismatch for the last frame.
o_Frame_Err  output  1  a stop bit sampled low in the last frame.
o_Busy  output  1  high in every state except IDLE.

Behaviour:
Reset (asynchronous, active-high):
- o_RX_Valid = 0, o_RX_Byte = 0, o_Parity_Err = 0, o_Frame_Err = 0, o_Busy = 0.
- Synchroniser flops = 1. State = IDLE. All counters = 0.
- Reset asserted mid-frame aborts the frame immediately; no o_RX_Valid is produced.

Input path:
- 2-flop synchroniser, giving 2 cycles of latency; all logic below uses the synchronised line.

Sampling:
- Bit counter width is clog2(CLKS_PER_BIT). MID = (CLKS_PER_BIT-1)/2.
- Each bit's value is the majority of the line at counts MID-1, MID and MID+1.
- The bit decision is made at count MID+1. The counter then wraps to 0 at CLKS_PER_BIT-1.

States:
- IDLE: a synchronised low moves to START with the counter cleared.
- START: if the voted value is 1, return to IDLE. This is glitch rejection: no flags change and no pulse is issued. If the voted value is 0, go to DATA.
- DATA: shift in DATA_BITS voted bits, LSB first. Then go to PARITY if PARITY_MODE != 0, otherwise go to STOP.
- PARITY: even mode expects the XOR of the data bits plus the parity bit to be 0; odd mode expects 1. Record a mismatch internally. Go to STOP.
- STOP: vote STOP_BITS bits. Any stop bit that votes 0 sets the internal frame error.
  - At the decision point of the final stop bit: load o_RX_Byte, o_Parity_Err and o_Frame_Err, and pulse o_RX_Valid for exactly one cycle.
  - Then go to IDLE if there was no frame error, or to BREAK_WAIT if there was.
  - Re-arming at mid-stop-bit allows back-to-back frames with zero idle time.
- BREAK_WAIT: hold until the synchronised line is 1, then go to IDLE. A break or stuck-low line therefore yields exactly one errored frame, not a stream of them.

Output rules:
- o_RX_Byte and both error flags hold their values until the next o_RX_Valid.
- Latency: o_RX_Valid asserts 2 + MID + 1 clocks after the line's mid-point of the final stop bit edge reference, i.e. at the final stop-bit decision.
- PARITY_MODE = 0: o_Parity_Err is always 0.
- Illegal parameter values are rejected by an elaboration-time check.

Decomposition:
Shared package uart_pkg:
- State enumeration: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- PARITY_NONE, PARITY_EVEN and PARITY_ODD constants.
- A counter-width function built on clog2.
- The package is shared with the planned uart_tx_param.

Sub-module uart_rx_sync:
- 2-flop synchroniser with reset value 1 and an async active-high reset.
- Reused for all other asynchronous pin inputs.

Test Plan:
1. CLKS_PER_BIT=16, defaults; send 0xA5 as 8N1 -> exactly one o_RX_Valid pulse, o_RX_Byte = 0xA5, both error flags 0.
2. PARITY_MODE=1; send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first frame o_Parity_Err = 0, second frame o_Parity_Err = 1; o_RX_Byte = 0x07 for both.
3. STOP_BITS=2; send 0x3C with the second stop bit low, followed by 40 clocks of low line -> one pulse with o_Frame_Err = 1. No further pulses until the line returns high. A following valid 0x11 is received cleanly.
4. Glitch and noise: a 3-clock low pulse on an idle line -> no o_RX_Valid and o_Busy returns to 0. Then send 0x55 with one-clock inverted spikes at every mid-sample -> o_RX_Byte = 0x55 because the majority vote rejects the spikes.
5. Back-to-back: send 0x01, 0xFF, 0x80 with no idle gap -> three pulses in order with the correct words.
6. Assert i_Reset during bit 4 of a frame, then release it and send 0x9E -> no pulse for the aborted frame; every output is at its reset value while reset is held; 0x9E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver and transmitter.
package uart_pkg;

  // Receiver protocol states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  // Parity mode encodings used by the PARITY_MODE parameter.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Width of a counter that runs 0 .. clks_per_bit-1.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input pin.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta;

  // Resynchronise the pin; both flops reset to the idle-high level.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_Reset) begin
      meta   <= 1'b1;
      o_Sync <= 1'b1;
    end else begin
      meta   <= i_Async;
      o_Sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority vote, parity and framing checks.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Input,
  output logic                 o_RX_Valid,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CW  = cnt_width(CLKS_PER_BIT);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic          LAST_STP = 1'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration.
  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 samp_a_q, samp_b_q;
  logic                 vote, decide, last_stop;
  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, frm_err_q;

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_RX_Input),
    .o_Sync  (rx_s)
  );

  // Majority of the samples at MID-1, MID and MID+1; decision is taken at MID+1.
  always_comb begin
    decide    = (cnt_q == CNT_DEC);
    vote      = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
    last_stop = (stop_idx_q == LAST_STP);
  end

  // State register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; state changes happen at bit decision points so frames can re-arm mid-stop-bit.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:       if (!rx_s) state_d = START;
      START:      if (decide) state_d = vote ? IDLE : DATA;
      DATA:       if (decide && bit_idx_q == LAST_BIT)
                    state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      PARITY:     if (decide) state_d = STOP;
      STOP:       if (decide && last_stop)
                    state_d = (frm_err_q || !vote) ? BREAK_WAIT : IDLE;
      BREAK_WAIT: if (rx_s) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  assign o_Busy = (state_q != IDLE);

  // Bit timing, sampling, data shifting, error tracking and output registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q        <= '0;
      samp_a_q     <= 1'b1;
      samp_b_q     <= 1'b1;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      o_RX_Valid   <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      o_RX_Valid <= 1'b0;

      if (state_q == IDLE || state_q == BREAK_WAIT) cnt_q <= '0;
      else if (cnt_q == CNT_LAST)                   cnt_q <= '0;
      else                                          cnt_q <= cnt_q + 1'b1;

      if (cnt_q == CNT_S0) samp_a_q <= rx_s;
      if (cnt_q == CNT_S1) samp_b_q <= rx_s;

      if (decide) begin
        case (state_q)
          START: begin
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
          end
          DATA: begin
            shift_q   <= {vote, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
          end
          PARITY: par_err_q <= ((^shift_q) ^ vote) != (PARITY_MODE == PARITY_ODD);
          STOP: begin
            if (!vote) frm_err_q <= 1'b1;
            stop_idx_q <= stop_idx_q + 1'b1;
            if (last_stop) begin
              o_RX_Valid   <= 1'b1;
              o_RX_Byte    <= shift_q;
              o_Parity_Err <= par_err_q;
              o_Frame_Err  <= frm_err_q | ~vote;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: three receivers (8N1, 8E1, 8N2) driven with directed and random frames.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic i_Clock = 1'b0;
  logic i_Reset;
  logic rx_a, rx_b, rx_c;
  logic v_a, v_b, v_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, busy_a, busy_b, busy_c;
  logic [7:0] byte_a, byte_b, byte_c;

  int n_checks = 0;
  int n_errors = 0;

  // Received and expected frames: {dut[1:0], parity_err, frame_err, data[7:0]}.
  logic [11:0] rcv_q[$];
  logic [11:0] exp_q[$];

  always #5 i_Clock = ~i_Clock;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_RX_Input(rx_a), .o_RX_Valid(v_a),
    .o_RX_Byte(byte_a), .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_b (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_RX_Input(rx_b), .o_RX_Valid(v_b),
    .o_RX_Byte(byte_b), .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Busy(busy_b));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_dut_c (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_RX_Input(rx_c), .o_RX_Valid(v_c),
    .o_RX_Byte(byte_c), .o_Parity_Err(pe_c), .o_Frame_Err(fe_c), .o_Busy(busy_c));

  // Capture every valid pulse away from the active edge.
  always @(negedge i_Clock) begin
    if (v_a) rcv_q.push_back({2'd0, pe_a, fe_a, byte_a});
    if (v_b) rcv_q.push_back({2'd1, pe_b, fe_b, byte_b});
    if (v_c) rcv_q.push_back({2'd2, pe_c, fe_c, byte_c});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic val);
    case (sel)
      0:       rx_a = val;
      1:       rx_b = val;
      default: rx_c = val;
    endcase
  endtask

  // One serial bit; an optional one-clock inverted spike lands on the middle vote sample.
  task automatic drive_bit(input int sel, input logic val, input bit spike);
    for (int j = 0; j < CPB; j++) begin
      @(negedge i_Clock);
      set_line(sel, (spike && j == 8) ? ~val : val);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input logic pbit,
                            input logic s1, input logic s2, input bit spike, input int gap);
    drive_bit(sel, 1'b0, spike);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i], spike);
    if (sel == 1) drive_bit(sel, pbit, spike);
    drive_bit(sel, s1, spike);
    if (sel == 2) drive_bit(sel, s2, spike);
    for (int g = 0; g < gap; g++) begin
      @(negedge i_Clock);
      set_line(sel, 1'b1);
    end
  endtask

  // Reference model: what a frame with these wire bits must report.
  task automatic expect_frame(input int sel, input logic [7:0] data, input logic pbit,
                              input logic s1, input logic s2);
    logic perr, ferr;
    perr = (sel == 1) ? ((($countones(data) + int'(pbit)) % 2) != 0) : 1'b0;
    ferr = (s1 == 1'b0) || (sel == 2 && s2 == 1'b0);
    exp_q.push_back({2'(sel), perr, ferr, data});
  endtask

  // Wait (bounded) for the expected pulses, then compare count and contents in order.
  task automatic drain(input string tag);
    int t;
    logic [11:0] e, g;
    t = 0;
    while (rcv_q.size() < exp_q.size() && t < 600) begin
      @(negedge i_Clock);
      t++;
    end
    repeat (40) @(negedge i_Clock);
    check({tag, " pulse count"}, rcv_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (rcv_q.size() > 0) ? rcv_q.pop_front() : 12'hFFF;
      check({tag, " frame"}, {20'd0, g}, {20'd0, e});
    end
    rcv_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, {31'd0, v_a}, 32'd0);
    check({tag, " byte"}, {24'd0, byte_a}, 32'd0);
    check({tag, " parity_err"}, {31'd0, pe_a}, 32'd0);
    check({tag, " frame_err"}, {31'd0, fe_a}, 32'd0);
    check({tag, " busy"}, {29'd0, busy_a, busy_b, busy_c}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic p, s1, s2;
    bit sp;
    int sel;

    i_Reset = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    repeat (3) @(negedge i_Clock);
    check_reset_outputs("reset");
    i_Reset = 1'b0;
    repeat (5) @(negedge i_Clock);

    // Plain 8N1 frame.
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    expect_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    drain("8n1 a5");

    // Even parity: correct then wrong parity bit.
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    expect_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    expect_frame(1, 8'h07, 1'b0, 1'b1, 1'b1);
    drain("even parity");

    // Two stop bits, second one low, then a break; exactly one errored frame.
    send_frame(2, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    expect_frame(2, 8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (40) begin
      @(negedge i_Clock);
      set_line(2, 1'b0);
    end
    drain("break frame");
    @(negedge i_Clock);
    set_line(2, 1'b1);
    repeat (10) @(negedge i_Clock);
    send_frame(2, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    expect_frame(2, 8'h11, 1'b0, 1'b1, 1'b1);
    drain("after break");

    // Short glitch is rejected in START and the receiver returns to idle.
    repeat (3) begin
      @(negedge i_Clock);
      set_line(0, 1'b0);
    end
    @(negedge i_Clock);
    set_line(0, 1'b1);
    repeat (2) @(negedge i_Clock);
    check("glitch busy high", {31'd0, busy_a}, 32'd1);
    repeat (30) @(negedge i_Clock);
    check("glitch busy low", {31'd0, busy_a}, 32'd0);
    drain("glitch");

    // Mid-sample spikes are out-voted.
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 4);
    expect_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
    drain("spiked 55");

    // Back-to-back frames with no idle time.
    send_frame(0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    expect_frame(0, 8'h01, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    expect_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    expect_frame(0, 8'h80, 1'b0, 1'b1, 1'b1);
    drain("back to back");

    // Reset in the middle of data bit 4 aborts the frame.
    d = 8'hC3;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i], 1'b0);
    repeat (8) begin
      @(negedge i_Clock);
      set_line(0, d[4]);
    end
    @(negedge i_Clock);
    i_Reset = 1'b1;
    set_line(0, 1'b1);
    repeat (2) @(negedge i_Clock);
    check_reset_outputs("mid-frame reset");
    i_Reset = 1'b0;
    repeat (5) @(negedge i_Clock);
    send_frame(0, 8'h9E, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    expect_frame(0, 8'h9E, 1'b0, 1'b1, 1'b1);
    drain("after reset");

    // Randomised frames across all three configurations.
    for (int k = 0; k < 24; k++) begin
      sel = k % 3;
      d   = 8'($urandom);
      p   = 1'($urandom);
      s1  = ($urandom_range(0, 5) != 0);
      s2  = (sel == 2) ? ($urandom_range(0, 5) != 0) : 1'b1;
      sp  = 1'($urandom_range(0, 1));
      send_frame(sel, d, p, s1, s2, sp, (s1 && s2) ? int'($urandom_range(0, 3)) : 8);
      expect_frame(sel, d, p, s1, s2);
      drain("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
